// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers, one transfer in flight, and returns one response per command
// (read data, slave error, or timeout).
module apb_cmd_master #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    // command stream
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic                cmd_prot,
    // response stream
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    // APB requester
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic                pprot,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    // Wide enough to hold TIMEOUT_CYCLES itself; one bit when the timeout is off.
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q,       state_d;
    logic                psel_q,        psel_d;
    logic                penable_q,     penable_d;
    logic                pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,       pstrb_d;
    logic                pprot_q,       pprot_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_err_q,     rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;

    // Counter value including the current ACCESS cycle; the timeout fires when it
    // reaches the limit, giving exactly TIMEOUT_CYCLES ACCESS cycles.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Only cmd_ready is combinational; every other output comes straight from a flop.
    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        // NOTE: every _d gets a hold default before the case so no path infers a latch.
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                // The APB output registers double as the command latch.
                if (cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    pprot_d   = cmd_prot;
                    cnt_d     = '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                cnt_d = cnt_inc;
                // pready has priority over a timeout landing in the same cycle.
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: a directed vector table, hand-written
// backpressure / timeout / reset sequences, and a randomized run scored against
// a transaction-level memory model.
module tb_apb_cmd_master;

    localparam int MAIN_TO = 256;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        cmd_prot;
    logic        rsp_ready;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    // main instance (default timeout)
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, pwdata;
    logic        psel, penable, pwrite, pprot;
    logic [15:0] paddr;
    logic [3:0]  pstrb;

    // short-timeout instance, fed the same inputs
    logic        cmd_ready_t, rsp_valid_t, rsp_err_t, rsp_timeout_t;
    logic [31:0] rsp_rdata_t, pwdata_t;
    logic        psel_t, penable_t, pwrite_t, pprot_t;
    logic [15:0] paddr_t;
    logic [3:0]  pstrb_t;

    apb_cmd_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(MAIN_TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb_cmd_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_t), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_t),
        .rsp_err(rsp_err_t), .rsp_timeout(rsp_timeout_t),
        .psel(psel_t), .penable(penable_t), .pwrite(pwrite_t), .paddr(paddr_t),
        .pwdata(pwdata_t), .pstrb(pstrb_t), .pprot(pprot_t),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    int checks   = 0;
    int failures = 0;

    // slave behaviour knobs and slave-side storage
    int          wait_cfg = 0;
    logic        err_cfg  = 1'b0;
    int          wait_left = 0;
    logic [31:0] slave_mem [64];

    // reference model storage
    logic [31:0] ref_mem [64];

    // response of the short-timeout instance, captured when the main one responds
    logic        t_valid, t_err, t_tout;
    logic [31:0] t_rdata;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        serr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // APB slave: pready stuck high outside ACCESS with junk data, programmable
    // wait states and error inside ACCESS.
    initial begin
        pready  = 1'b1;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && !penable) wait_left = wait_cfg;
            if (psel && penable) begin
                if (wait_left > 0) begin
                    pready    = 1'b0;
                    prdata    = $urandom;
                    pslverr   = 1'($urandom_range(0, 1));
                    wait_left = wait_left - 1;
                end else begin
                    pready  = 1'b1;
                    pslverr = err_cfg;
                    prdata  = pwrite ? $urandom : slave_mem[paddr[7:2]];
                    if (pwrite && !err_cfg)
                        for (int b = 0; b < 4; b++)
                            if (pstrb[b]) slave_mem[paddr[7:2]][8*b +: 8] = pwdata[8*b +: 8];
                end
            end else begin
                pready  = 1'b1;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    // Transaction-level expectation: memory with byte strobes, erroring writes
    // are dropped, latency is 3 cycles plus wait states unless the timeout wins.
    task automatic model(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic serr, input int limit,
                         output logic [31:0] e_rdata, output logic e_err, output logic e_tout,
                         output int e_lat);
        int idx;
        idx = int'(addr[7:2]);
        if (limit != 0 && waits >= limit) begin
            e_rdata = '0; e_err = 1'b1; e_tout = 1'b1; e_lat = 2 + limit;
        end else begin
            e_err = serr; e_tout = 1'b0; e_lat = 3 + waits;
            if (wr) begin
                e_rdata = '0;
                if (!serr)
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e_rdata = ref_mem[idx];
            end
        end
    endtask

    // Drive one command on the main instance, check APB phases, hold the
    // response for 'hold' cycles, then consume it.
    task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic prot, input int waits,
                           input logic serr, input int hold,
                           output logic [31:0] rdata, output logic err, output logic tout,
                           output int lat);
        int   n;
        logic stable;
        logic hold_ok;
        logic [3:0] exp_strb;
        exp_strb  = wr ? strb : 4'h0;
        wait_cfg  = waits;
        err_cfg   = serr;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("setup_phase",  {psel, penable}, 2'b10);
        check("setup_paddr",  paddr, addr);
        check("setup_pwrite", pwrite, wr);
        check("setup_pwdata", pwdata, wdata);
        check("setup_pstrb",  pstrb, exp_strb);
        check("setup_pprot",  pprot, prot);
        check("setup_no_rsp", {rsp_valid, cmd_ready}, 2'b00);
        tick();
        lat = 2;
        stable = 1'b1;
        while (!rsp_valid && lat < 300) begin
            if (!(psel && penable && paddr == addr && pwdata == wdata && pwrite == wr &&
                  pstrb == exp_strb && pprot == prot && !cmd_ready)) stable = 1'b0;
            tick();
            lat++;
        end
        check("access_stable", stable, 1);
        check("rsp_valid_seen", rsp_valid, 1);
        check("resp_apb_idle", {psel, penable, cmd_ready}, 3'b000);
        rdata = rsp_rdata; err = rsp_err; tout = rsp_timeout;
        t_valid = rsp_valid_t; t_rdata = rsp_rdata_t; t_err = rsp_err_t; t_tout = rsp_timeout_t;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!rsp_valid || rsp_rdata != rdata || rsp_err != err || rsp_timeout != tout ||
                cmd_ready || psel) hold_ok = 1'b0;
        end
        if (hold > 0) check("resp_hold_stable", hold_ok, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("resp_consumed", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin : main
        logic [31:0] rdata, e_rdata;
        logic        err, tout, e_err, e_tout;
        int          lat, e_lat, n, nacc;
        logic        st;
        logic        r_wr, r_prot, r_serr;
        logic [15:0] r_addr;
        logic [31:0] r_wdata;
        logic [3:0]  r_strb;
        int          r_waits, r_hold;

        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = 32'(i) * 32'h0101_0101;
            ref_mem[i]   = 32'(i) * 32'h0101_0101;
        end
        cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = 1'b0;
        do_reset();

        // reset state
        check("rst_apb",   {psel, penable, pwrite, pprot}, 4'b0000);
        check("rst_paddr", paddr, 0);
        check("rst_pdata", {pwdata, pstrb}, 0);
        check("rst_rsp",   {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_ready", cmd_ready, 1);

        // wr addr wdata strb waits serr exp_rdata exp_err exp_lat
        vecs[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b0, 16'h0010, 32'h5555_5555, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2] = '{1'b1, 16'h0004, 32'h0000_1234, 4'hF, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
        vecs[3] = '{1'b0, 16'h0004, 32'h0000_0000, 4'hF, 0, 1'b1, 32'h0000_1234, 1'b1, 3};
        vecs[4] = '{1'b1, 16'h0010, 32'h1122_3344, 4'h5, 5, 1'b0, 32'h0000_0000, 1'b0, 8};
        vecs[5] = '{1'b0, 16'h0010, 32'h0000_0000, 4'h3, 5, 1'b0, 32'hDE22_BE44, 1'b0, 8};
        vecs[6] = '{1'b1, 16'h0008, 32'hCAFE_F00D, 4'hF, 0, 1'b1, 32'h0000_0000, 1'b1, 3};
        vecs[7] = '{1'b0, 16'h0008, 32'h0000_0000, 4'h0, 2, 1'b0, 32'h0202_0202, 1'b0, 5};

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'(i % 2),
                    vecs[i].waits, vecs[i].serr, 0, rdata, err, tout, lat);
            model(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits,
                  vecs[i].serr, MAIN_TO, e_rdata, e_err, e_tout, e_lat);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {err, tout}, {vecs[i].exp_err, 1'b0});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // response backpressure with a second command waiting
        wait_cfg = 0; err_cfg = 1'b0;
        cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_valid = 1'b1;
        check("bp_idle_ready", cmd_ready, 1);
        tick();
        cmd_write = 1'b1; cmd_addr = 16'h0014; cmd_wdata = 32'hA5A5_5A5A; cmd_strb = 4'hF;
        cmd_prot = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin tick(); lat++; end
        check("bp_latency", lat, 3);
        rdata = rsp_rdata; err = rsp_err;
        check("bp_rdata", rdata, 32'hDE22_BE44);
        check("bp_err", {err, rsp_timeout}, 2'b00);
        st = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_rdata != rdata || rsp_err != err || rsp_timeout || cmd_ready || psel)
                st = 1'b0;
            tick();
        end
        check("bp_stable", st, 1);
        rsp_ready = 1'b1;
        check("bp_ready_low_at_consume", cmd_ready, 0);
        tick();
        rsp_ready = 1'b0;
        check("bp_after_consume", {rsp_valid, cmd_ready, psel}, 3'b010);
        tick();
        cmd_valid = 1'b0;
        check("bp_second_setup", {psel, penable}, 2'b10);
        check("bp_second_paddr", paddr, 16'h0014);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check("bp_second_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        model(1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b0, MAIN_TO, e_rdata, e_err, e_tout, e_lat);
        model(1'b1, 16'h0014, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, MAIN_TO, e_rdata, e_err, e_tout, e_lat);

        // timeout on the 4-cycle instance, twice to show the counter restarts
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wait_cfg = 1000; err_cfg = 1'b0;
            cmd_write = 1'b0; cmd_addr = 16'h0030; cmd_wdata = 32'h0BAD_F00D;
            cmd_strb = 4'hF; cmd_prot = 1'b1; cmd_valid = 1'b1;
            check("to_cmd_ready", cmd_ready_t, 1);
            tick();
            cmd_valid = 1'b0;
            lat = 1; nacc = 0; st = 1'b1;
            while (!rsp_valid_t && lat < 50) begin
                if (psel_t && penable_t) nacc++;
                if (!(psel_t && paddr_t == 16'h0030 && !pwrite_t && pstrb_t == 4'h0 &&
                      pwdata_t == 32'h0BAD_F00D && pprot_t)) st = 1'b0;
                tick();
                lat++;
            end
            check("to_apb_stable", st, 1);
            check("to_access_cycles", nacc, 4);
            check("to_latency", lat, 6);
            check("to_psel", {psel_t, penable_t}, 2'b00);
            check("to_flags", {rsp_err_t, rsp_timeout_t}, 2'b11);
            check("to_rdata", rsp_rdata_t, 0);
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
            check("to_done", {rsp_valid_t, cmd_ready_t}, 2'b01);
        end

        // pready arriving in the cycle the timeout would fire wins
        do_reset();
        run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 3, 1'b0, 0, rdata, err, tout, lat);
        model(1'b0, 16'h0010, 32'h0, 4'h0, 3, 1'b0, 4, e_rdata, e_err, e_tout, e_lat);
        check("race_valid", t_valid, 1);
        check("race_flags", {t_err, t_tout}, {e_err, e_tout});
        check("race_rdata", t_rdata, e_rdata);

        // reset while in ACCESS, then a normal write and read-back
        wait_cfg = 1000; err_cfg = 1'b0;
        cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
        cmd_valid = 1'b1;
        check("rstmid_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!penable && n < 20) begin tick(); n++; end
        check("rstmid_penable", penable, 1);
        rst = 1'b1;
        tick();
        check("rstmid_apb", {psel, penable}, 2'b00);
        check("rstmid_rsp", {rsp_valid, cmd_ready}, 2'b01);
        rst = 1'b0;
        run_cmd(1'b1, 16'h0020, 32'h1357_9BDF, 4'hF, 1'b0, 0, 1'b0, 0, rdata, err, tout, lat);
        model(1'b1, 16'h0020, 32'h1357_9BDF, 4'hF, 0, 1'b0, MAIN_TO, e_rdata, e_err, e_tout, e_lat);
        check("post_rst_wr", {err, tout, lat}, {e_err, e_tout, e_lat});
        run_cmd(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, rdata, err, tout, lat);
        model(1'b0, 16'h0020, 32'h0, 4'h0, 0, 1'b0, MAIN_TO, e_rdata, e_err, e_tout, e_lat);
        check("post_rst_rd", rdata, e_rdata);
        check("post_rst_rd_val", rdata, 32'h1357_9BDF);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = {8'($urandom), 6'($urandom_range(0, 63)), 2'b00};
            r_wdata = $urandom;
            r_strb  = 4'($urandom);
            r_prot  = 1'($urandom_range(0, 1));
            r_waits = $urandom_range(0, 3);
            r_serr  = ($urandom_range(0, 7) == 0);
            r_hold  = $urandom_range(0, 2);
            run_cmd(r_wr, r_addr, r_wdata, r_strb, r_prot, r_waits, r_serr, r_hold,
                    rdata, err, tout, lat);
            model(r_wr, r_addr, r_wdata, r_strb, r_waits, r_serr, MAIN_TO,
                  e_rdata, e_err, e_tout, e_lat);
            check("rand_rdata", rdata, e_rdata);
            check("rand_flags", {err, tout}, {e_err, e_tout});
            check("rand_latency", lat, e_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers. It drives the APB slave memory model directly and sits between the bench or system command source and that slave. It returns one response per command: read data, slave error, or a timeout flag. One transfer is in flight at a time, with no pipelining across transfers.

Parameters:
ADDR_W, 16, APB address width.
DATA_W, 32, APB data width. pstrb width is DATA_W/8.
TIMEOUT_CYCLES, 256, maximum ACCESS cycles to wait for pready. A value of 0 disables the timeout.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
cmd_prot  in  1  forwarded to pprot
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes; forced to 0 on reads
pprot  out  1  APB protection
pready  in  1  slave ready
prdata  in  DATA_W  slave read data
pslverr  in  1  slave error

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high rst, sampled on the rising edge of clk.
- Registered outputs: all outputs are registered except cmd_ready, which is combinational and equal to (state == IDLE).
- Reset values: state = IDLE. psel, penable, pwrite, pprot, rsp_valid, rsp_err and rsp_timeout = 0. paddr, pwdata, pstrb and rsp_rdata = 0. Timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch write, addr, wdata, strb and prot, then go to SETUP.
  - psel and penable are 0. paddr, pwdata and pwrite hold their last values.
- SETUP (exactly 1 cycle):
  - psel = 1, penable = 0.
  - paddr, pwrite, pwdata and pprot take the latched values.
  - pstrb = latched strb if write, otherwise 0.
  - Next state is ACCESS.
- ACCESS:
  - psel = 1 and penable = 1. All APB address/data/control outputs are held stable.
  - Counter increments once per ACCESS cycle.
  - If pready is sampled high: capture rsp_rdata = (read ? prdata : 0), rsp_err = pslverr, rsp_timeout = 0. Deassert psel and penable, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1. Deassert psel and penable, go to RESP.
  - If pready is high in the same cycle the timeout would fire, pready wins and no timeout is reported.
- RESP:
  - rsp_valid = 1. Response fields are held stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0, go to IDLE, clear the counter.
  - psel = 0 throughout RESP.
- Latency with zero wait states: accept edge, then SETUP, then ACCESS, then rsp_valid. rsp_valid rises 3 cycles after the accept edge.
- Each extra low-pready cycle adds 1 cycle of latency.
- Minimum command-to-command spacing is 4 cycles. cmd_ready is low from the accept edge until RESP completes.
- pslverr and prdata are ignored outside ACCESS or when pready is low.
- A pready that is stuck high (as the slave model produces after its first transfer) still requires a full SETUP and one ACCESS cycle. No transfer skips SETUP.
- Reset mid-transfer: psel and penable drop in the next cycle, and any pending response is discarded.

Test Plan:
- Write then read, zero waits: write addr 0x0010, data 0xDEADBEEF, strb 0xF, then read 0x0010. Required: a SETUP cycle with psel=1, penable=0, then ACCESS. rsp_valid rises 3 cycles after accept. Read rsp_rdata = 0xDEADBEEF, rsp_err = 0. pstrb = 0 during the read.
- Wait states: responder holds pready low for 5 ACCESS cycles. Required: paddr, pwdata, pwrite and penable stable for all 6 ACCESS cycles, and rsp_valid rises 8 cycles after accept.
- Slave error: pready=1 and pslverr=1 on a read of 0x0004 with prdata=0x1234. Required: rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0x1234.
- Timeout: TIMEOUT_CYCLES = 4 with pready held low. Required: exactly 4 ACCESS cycles, then psel = 0. Response has rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Response backpressure: rsp_ready held low for 10 cycles. Required: rsp_valid and the response fields stable, cmd_ready = 0, and a second cmd_valid is not accepted until 1 cycle after rsp_ready.
- Reset mid-ACCESS: assert rst while penable = 1. Required: the next cycle has psel = 0, penable = 0, rsp_valid = 0, cmd_ready = 1. A following write to 0x0020 completes normally.
